// File: rtl/risc_div_pkg.sv
// Shared types and helpers for the multi-cycle integer divider.
// Holds the FSM state encoding, the divide-by-zero quotient and the conditional negate.
package risc_div_pkg;

    localparam int MAX_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam logic [MAX_W-1:0] DIV_ZERO_Q = '1;

    // Two's-complement negate when requested; callers zero-extend and keep the low WIDTH bits.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] value,
                                                  input logic             negate);
        return negate ? (~value + MAX_W'(1)) : value;
    endfunction

endpackage

// File: rtl/risc_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract, keep if non-negative.
module risc_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             borrow;
    logic             unused_step;

    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b00, divisor};
    assign borrow  = trial[WIDTH+1];

    // Both the kept difference and a restored value are below the divisor, so WIDTH bits suffice.
    assign rem_out     = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_out     = {quo_in[WIDTH-2:0], ~borrow};
    assign unused_step = shifted[WIDTH] ^ trial[WIDTH];

endmodule

// File: rtl/risc_div_unit.sv
// Multi-cycle signed/unsigned divider for the execute stage: captures operands on start,
// stalls the pipeline while iterating, and returns results with a one-cycle done pulse.
module risc_div_unit
    import risc_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [TAG_W-1:0] dest_in,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [TAG_W-1:0] dest_out,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_reg, state_next;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] rem_reg, quo_reg, dvsr_reg;
    logic             q_neg_reg, r_neg_reg;
    logic [TAG_W-1:0] tag_reg;

    logic [WIDTH-1:0] quotient_reg, remainder_reg;
    logic [TAG_W-1:0] dest_out_reg;
    logic             div_by_zero_reg, overflow_reg;

    logic             a_neg, b_neg, is_zero, is_ovf, fast_path, accept;
    logic [WIDTH-1:0] step_rem, step_quo;

    // Slot 0/1: operand magnitudes; slot 2/3: sign fix-up of quotient/remainder.
    logic [MAX_W-1:0] neg_in  [4];
    logic [MAX_W-1:0] neg_out [4];
    logic             neg_sel [4];
    logic             unused_hi;

    assign a_neg     = signed_op & dividend[WIDTH-1];
    assign b_neg     = signed_op & divisor[WIDTH-1];
    assign is_zero   = (divisor == '0);
    assign is_ovf    = signed_op && (dividend == MIN_VAL) && (divisor == '1);
    assign fast_path = is_zero | is_ovf;
    assign accept    = (state_reg == IDLE) && start && !flush;

    assign neg_in[0]  = MAX_W'(dividend);
    assign neg_in[1]  = MAX_W'(divisor);
    assign neg_in[2]  = MAX_W'(quo_reg);
    assign neg_in[3]  = MAX_W'(rem_reg);
    assign neg_sel[0] = a_neg;
    assign neg_sel[1] = b_neg;
    assign neg_sel[2] = q_neg_reg;
    assign neg_sel[3] = r_neg_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_neg
            assign neg_out[gi] = cond_neg(neg_in[gi], neg_sel[gi]);
        end
    endgenerate

    assign unused_hi = ^{neg_out[0][MAX_W-1:WIDTH], neg_out[1][MAX_W-1:WIDTH],
                         neg_out[2][MAX_W-1:WIDTH], neg_out[3][MAX_W-1:WIDTH]};

    risc_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in (rem_reg),
        .quo_in (quo_reg),
        .divisor(dvsr_reg),
        .rem_out(step_rem),
        .quo_out(step_quo)
    );

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        busy       = (state_reg != IDLE);
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                stall = start & ~fast_path;
                if (start && !flush) begin
                    state_next = fast_path ? DONE : CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (flush) begin
                    state_next = IDLE;
                end else if (count_reg == LAST_STEP) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                stall      = 1'b1;
                state_next = flush ? IDLE : DONE;
            end
            DONE: begin
                done       = ~flush & ~rst;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            rem_reg         <= '0;
            quo_reg         <= '0;
            dvsr_reg        <= '0;
            q_neg_reg       <= 1'b0;
            r_neg_reg       <= 1'b0;
            tag_reg         <= '0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            dest_out_reg    <= '0;
            div_by_zero_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        count_reg       <= '0;
                        rem_reg         <= '0;
                        quo_reg         <= neg_out[0][WIDTH-1:0];
                        dvsr_reg        <= neg_out[1][WIDTH-1:0];
                        q_neg_reg       <= a_neg ^ b_neg;
                        r_neg_reg       <= a_neg;
                        tag_reg         <= dest_in;
                        div_by_zero_reg <= is_zero;
                        overflow_reg    <= is_ovf;
                        // Fast paths skip iteration, so results are loaded on the issue edge.
                        if (fast_path) begin
                            quotient_reg  <= is_zero ? DIV_ZERO_Q[WIDTH-1:0] : dividend;
                            remainder_reg <= is_zero ? dividend : '0;
                            dest_out_reg  <= dest_in;
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        rem_reg   <= step_rem;
                        quo_reg   <= step_quo;
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (!flush) begin
                        quotient_reg  <= neg_out[2][WIDTH-1:0];
                        remainder_reg <= neg_out[3][WIDTH-1:0];
                        dest_out_reg  <= tag_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign dest_out    = dest_out_reg;
    assign div_by_zero = div_by_zero_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_risc_div_unit.sv
// Scoreboard bench for risc_div_unit: expected results queued at issue, compared on done.
module tb_risc_div_unit;

    localparam int W     = 32;
    localparam int TW    = 5;
    localparam int BOUND = W + 8;

    logic          clk, rst, start, signed_op, flush;
    logic [W-1:0]  dividend, divisor;
    logic [TW-1:0] dest_in;
    logic          stall, busy, done, div_by_zero, overflow;
    logic [W-1:0]  quotient, remainder;
    logic [TW-1:0] dest_out;

    typedef struct {
        logic [W-1:0]  q;
        logic [W-1:0]  r;
        logic [TW-1:0] tag;
        logic          dbz;
        logic          ovf;
        int            lat;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [W-1:0]  last_q   = '0;
    logic [W-1:0]  last_r   = '0;
    logic [TW-1:0] last_tag = '0;

    risc_div_unit #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .dest_in(dest_in), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .dest_out(dest_out),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic sop, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [TW-1:0] tag);
        exp_t e;
        e.tag = tag; e.dbz = 1'b0; e.ovf = 1'b0; e.lat = W + 2;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1;
        end else if (sop && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a; e.r = '0; e.ovf = 1'b1; e.lat = 1;
        end else if (sop) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Called one step after a posedge; start is driven for cycle 0 of the operation.
    task automatic run_op(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] tag, input int flush_at, input int inject_at,
                          input int rst_at);
        exp_t e, got_e;
        bit   abort, seen;
        int   stall_cnt;
        e     = model(sop, a, b, tag);
        abort = (flush_at > 0) || (rst_at > 0);
        if (!abort) sb.push_back(e);
        start = 1'b1; signed_op = sop; dividend = a; divisor = b; dest_in = tag;
        @(negedge clk);
        check("issue_stall", stall, (e.lat != 1));
        check("done_low_at_issue", done, 0);
        stall_cnt = stall ? 1 : 0;
        seen      = 1'b0;
        for (int i = 1; i <= BOUND && !seen; i++) begin
            @(posedge clk); #1;
            start = (i == inject_at);
            if (i == inject_at) begin
                signed_op = 1'b0; dividend = 50; divisor = 5; dest_in = tag ^ 5'h1;
            end
            flush = (i == flush_at);
            rst   = (i == rst_at);
            @(negedge clk);
            if (flush_at > 0 && i == flush_at + 1) check("flush_idle", busy, 0);
            if (rst_at > 0 && i == rst_at + 1) begin
                check("rst_q", quotient, 0);
                check("rst_r", remainder, 0);
                check("rst_tag", dest_out, 0);
                check("rst_busy", busy, 0);
                check("rst_flags", {div_by_zero, overflow, stall}, 0);
            end
            if (done) begin
                seen = 1'b1;
                if (abort || sb.size() == 0) begin
                    check("spurious_done", done, 0);
                end else begin
                    got_e = sb.pop_front();
                    check("quotient", quotient, got_e.q);
                    check("remainder", remainder, got_e.r);
                    check("dest_out", dest_out, got_e.tag);
                    check("div_by_zero", div_by_zero, got_e.dbz);
                    check("overflow", overflow, got_e.ovf);
                    check("latency", i, got_e.lat);
                    check("stall_in_done", stall, 0);
                    check("busy_in_done", busy, 1);
                    last_q = got_e.q; last_r = got_e.r; last_tag = got_e.tag;
                    $display("op %s %0h / %0h tag %0d -> q=%0h r=%0h at cycle %0d",
                             sop ? "signed" : "unsigned", a, b, tag, quotient, remainder, i);
                end
            end else if (stall) begin
                stall_cnt++;
            end
        end
        if (!abort) begin
            if (!seen) check("done_timeout", 0, 1);
            check("stall_cycles", stall_cnt, (e.lat == 1) ? 0 : e.lat);
        end
        if (flush_at > 0) begin
            check("flush_hold_q", quotient, last_q);
            check("flush_hold_r", remainder, last_r);
            check("flush_hold_tag", dest_out, last_tag);
            check("flush_flags", {div_by_zero, overflow}, 0);
            $display("op %0h / %0h flushed at cycle %0d", a, b, flush_at);
        end
        if (rst_at > 0) begin
            last_q = '0; last_r = '0; last_tag = '0;
            $display("op %0h / %0h reset at cycle %0d", a, b, rst_at);
        end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; signed_op = 1'b0; flush = 1'b0;
        dividend = '0; divisor = '0; dest_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_q", quotient, 0);
        check("reset_r", remainder, 0);
        check("reset_tag", dest_out, 0);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_stall", stall, 0);
        check("reset_flags", {div_by_zero, overflow}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(1'b0, 32'd100, 32'd7, 5'd3, 0, 0, 0);
        run_op(1'b1, -32'sd7, 32'd2, 5'd4, 0, 0, 0);
        run_op(1'b1, 32'd7, -32'sd2, 5'd5, 0, 0, 0);
        run_op(1'b0, 32'd5, 32'd0, 5'd6, 0, 0, 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0, 0, 0);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, 0, 0);
        run_op(1'b0, 32'd100, 32'd7, 5'd9, 10, 0, 0);
        run_op(1'b0, 32'd9, 32'd3, 5'd10, 0, 0, 0);
        run_op(1'b0, 32'd100, 32'd7, 5'd11, 0, 5, 0);
        run_op(1'b1, 32'h8000_0000, 32'd1, 5'd12, 0, 0, 0);
        run_op(1'b1, -32'sd100, -32'sd7, 5'd13, 0, 0, 0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 5'd14, 0, 0, 0);
        run_op(1'b0, 32'd3, 32'd10, 5'd15, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            run_op(k[0], $urandom, $urandom_range(1, 1000), 5'(16 + k), 0, 0, 0);
        end
        run_op(1'b0, 32'd1234, 32'd10, 5'd20, 0, 0, 20);
        run_op(1'b1, -32'sd50, 32'd5, 5'd21, 0, 0, 0);

        if (sb.size() != 0) check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
